// File: rtl/sample_and_hold_mc.sv
// Multi-channel windowed sample-and-hold: per window emits the last sample,
// the peak or the sum of each channel, with a one-cycle valid/sync qualifier.
module sample_and_hold_mc #(
  parameter  int unsigned WIDTH          = 8,
  parameter  int unsigned CHANNELS       = 4,
  parameter  int unsigned PERIOD_BITS    = 16,
  parameter  int unsigned DEFAULT_PERIOD = 128,
  parameter  int unsigned DEFAULT_MODE   = 0,
  localparam int unsigned OUT_WIDTH      = WIDTH + PERIOD_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sync,
  input  logic [PERIOD_BITS-1:0]        period,
  input  logic [1:0]                    mode,
  input  logic [CHANNELS*WIDTH-1:0]     din,
  output logic [CHANNELS*OUT_WIDTH-1:0] dout,
  output logic                          dout_valid,
  output logic                          dout_sync
);

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_PEAK   = 2'd1,
    MODE_SUM    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [PERIOD_BITS-1:0] P_RESET =
    (DEFAULT_PERIOD == 0) ? PERIOD_BITS'(1) : PERIOD_BITS'(DEFAULT_PERIOD);
  localparam logic [1:0] M_RESET = 2'(DEFAULT_MODE);

  logic [PERIOD_BITS-1:0] r_ctr;
  logic [PERIOD_BITS-1:0] r_p_lat;
  mode_e                  r_m_lat;
  logic                   r_valid;
  logic                   r_sync;
  logic                   w_end;
  logic                   w_accum;

  assign w_end      = sync || (r_ctr == (r_p_lat - PERIOD_BITS'(1)));
  assign w_accum    = (r_m_lat == MODE_PEAK) || (r_m_lat == MODE_SUM);
  assign dout_valid = r_valid;
  assign dout_sync  = r_sync;

  // Shared window counter, latched configuration and output qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr   <= '0;
      r_p_lat <= P_RESET;
      r_m_lat <= mode_e'(M_RESET);
      r_valid <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_valid <= w_end;
      r_sync  <= w_end && sync;
      if (w_end) begin
        r_ctr   <= '0;
        r_p_lat <= (period == '0) ? PERIOD_BITS'(1) : period;
        r_m_lat <= mode_e'(mode);
      end else begin
        r_ctr   <= r_ctr + PERIOD_BITS'(1);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [OUT_WIDTH-1:0] w_din;
    logic [OUT_WIDTH-1:0] w_op;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_dout;

    assign w_din = OUT_WIDTH'(din[g*WIDTH +: WIDTH]);
    assign dout[g*OUT_WIDTH +: OUT_WIDTH] = r_dout;

    // Window result including the current cycle's sample.
    always_comb begin
      w_op = w_din;
      case (r_m_lat)
        MODE_PEAK: w_op = (r_acc > w_din) ? r_acc : w_din;
        MODE_SUM:  w_op = r_acc + w_din;
        default:   w_op = w_din;
      endcase
    end

    // Accumulator restarts from zero at every window end and in sample mode.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_dout <= '0;
      end else begin
        if (w_end || !w_accum) begin
          r_acc <= '0;
        end else begin
          r_acc <= w_op;
        end
        if (w_end) begin
          r_dout <= w_op;
        end
      end
    end
  end

endmodule
